// File: rtl/list_walker.sv
// rtl/list_walker.sv - cons-cell list traversal engine streaming car values
module list_walker #(
    parameter logic [15:0] NIL_PTR = 16'h0000,
    parameter int          MAX_LEN = 1024,
    parameter int          TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] head_ptr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] elem_count,
    output logic        elem_valid,
    output logic [15:0] elem_data,
    input  logic        elem_ready,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_data_ready,
    input  logic [15:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_CAR, WT_CAR, EMIT, RD_CDR, WT_CDR, FIN
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cur;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        at_nil;
    logic        at_limit;

    assign tmo_hit  = (tmo_cnt == 16'(TIMEOUT - 1));
    assign at_nil   = (cur == NIL_PTR);
    assign at_limit = (elem_count == 12'(MAX_LEN));

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        elem_valid = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (at_nil || at_limit) state_nx = FIN;
                else                    state_nx = RD_CAR;
            end
            RD_CAR: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                state_nx = WT_CAR;
            end
            WT_CAR: begin
                busy = 1'b1;
                if (mem_data_ready) state_nx = EMIT;
                else if (tmo_hit)   state_nx = FIN;
            end
            EMIT: begin
                busy       = 1'b1;
                elem_valid = 1'b1;
                if (elem_ready) state_nx = RD_CDR;
            end
            RD_CDR: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                state_nx = WT_CDR;
            end
            WT_CDR: begin
                busy = 1'b1;
                if (mem_data_ready) state_nx = CHECK;
                else if (tmo_hit)   state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // mem_addr is loaded on the way into each RD_* state so it is already
    // valid when mem_req rises and stays put through the matching WT_* state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= 16'h0000;
            tmo_cnt    <= 16'h0000;
            err        <= 1'b0;
            elem_count <= 12'h000;
            elem_data  <= 16'h0000;
            mem_addr   <= 12'h000;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur        <= head_ptr;
                        elem_count <= 12'h000;
                        err        <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!at_nil && at_limit) err      <= 1'b1;
                    else if (!at_nil)        mem_addr <= cur[11:0];
                end
                RD_CAR, RD_CDR: begin
                    tmo_cnt <= 16'h0000;
                end
                WT_CAR: begin
                    if (mem_data_ready) elem_data <= mem_data;
                    else if (tmo_hit)   err       <= 1'b1;
                    else                tmo_cnt   <= tmo_cnt + 16'h0001;
                end
                EMIT: begin
                    if (elem_ready) begin
                        elem_count <= elem_count + 12'h001;
                        mem_addr   <= cur[11:0] + 12'h001;
                    end
                end
                WT_CDR: begin
                    if (mem_data_ready) cur     <= mem_data;
                    else if (tmo_hit)   err     <= 1'b1;
                    else                tmo_cnt <= tmo_cnt + 16'h0001;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_list_walker.sv
// tb/tb_list_walker.sv - randomized scoreboard bench for list_walker
module tb_list_walker;

    localparam int MAX_LEN = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [15:0] head_ptr = 16'h0000;
    logic        busy, done, err, elem_valid, elem_ready, mem_req;
    logic [11:0] elem_count, mem_addr;
    logic [15:0] elem_data;
    logic        mem_data_ready = 1'b0;
    logic [15:0] mem_data = 16'h0000;

    list_walker #(.NIL_PTR(16'h0000), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .head_ptr(head_ptr),
        .busy(busy), .done(done), .err(err), .elem_count(elem_count),
        .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [11:0] cnt;
    } end_t;

    logic [15:0] mem [4096];
    logic [15:0] exp_q[$];
    logic [11:0] addr_q[$];
    end_t        end_q[$];

    int   total = 0;
    int   bad = 0;
    bit   sb_off = 1'b0;
    bit   mem_mute = 1'b0;
    int   ready_mode = 0;
    bit   pending = 1'b0;
    int   delay = 0;
    logic [11:0] paddr = 12'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: follow the list through the bench memory image directly.
    task automatic model_walk(input logic [15:0] head, input bit mute);
        logic [15:0] p;
        logic [11:0] a;
        int          n;
        end_t        e;
        p = head;
        n = 0;
        e.err = 1'b0;
        if (mute) begin
            if (head != 16'h0000) addr_q.push_back(head[11:0]);
            e.err = (head != 16'h0000);
            e.cnt = 12'h000;
            end_q.push_back(e);
            return;
        end
        while (p != 16'h0000) begin
            if (n == MAX_LEN) begin
                e.err = 1'b1;
                break;
            end
            addr_q.push_back(p[11:0]);
            exp_q.push_back(mem[p[11:0]]);
            a = p[11:0] + 12'h001;
            addr_q.push_back(a);
            p = mem[a];
            n++;
        end
        e.cnt = 12'(n);
        end_q.push_back(e);
    endtask

    task automatic build_list(input int t, input int len, output logic [15:0] head);
        logic [15:0] nxt;
        logic [11:0] a;
        nxt = 16'h0000;
        for (int i = len - 1; i >= 0; i--) begin
            a = 12'(12'h100 + t * 32 + i * 4);
            mem[a] = 16'($urandom);
            mem[a + 12'h001] = nxt;
            nxt = {4'($urandom), a};
        end
        head = nxt;
    endtask

    task automatic run_walk(input logic [15:0] head, input bit mute, input bit inject, output int iter);
        mem_mute = mute;
        model_walk(head, mute);
        head_ptr = head;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        iter = 1;
        while (!done && iter < 3000) begin
            if (inject && busy && ($urandom % 3 == 0)) begin
                start = 1'b1;
                head_ptr = 16'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            iter++;
        end
        if (!done) check("walk_timeout", 32'(iter), 32'd0);
        @(posedge clk); #1;
        mem_mute = 1'b0;
    endtask

    // Memory responder: answers 1..3 cycles after a request, injects stray
    // data_ready pulses whenever the walker cannot legitimately consume them.
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_data_ready = 1'b0;
            mem_data = 16'($urandom);
            if (pending) begin
                if (!sb_off) check("addr_hold", mem_addr, paddr);
                if (delay == 0) begin
                    mem_data_ready = 1'b1;
                    mem_data = mem[paddr];
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end else if (mem_req && !rst) begin
                if (!sb_off) begin
                    if (addr_q.size() == 0) check("extra_req", {20'h0, mem_addr}, 32'hFFFFFFFF);
                    else check("mem_addr", mem_addr, addr_q.pop_front());
                end
                if (!mem_mute) begin
                    pending = 1'b1;
                    paddr = mem_addr;
                    delay = $urandom_range(0, 2);
                    if ($urandom % 4 == 0) mem_data_ready = 1'b1;
                end
            end else if (!mem_mute && ($urandom % 8 == 0)) begin
                mem_data_ready = 1'b1;
            end
        end
    end

    int hold_cnt = 0;
    initial begin
        elem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: elem_ready = 1'b1;
                1: elem_ready = 1'($urandom % 2);
                default: begin
                    if (elem_valid && hold_cnt < 5) begin
                        elem_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        elem_ready = elem_valid;
                        hold_cnt = 0;
                    end
                end
            endcase
        end
    end

    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    end_t        e_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !sb_off) begin
                if (elem_valid) check("no_req_in_emit", {31'h0, mem_req}, 32'd0);
                if (prev_stall && elem_valid) check("elem_hold", elem_data, prev_data);
                if (elem_valid && elem_ready) begin
                    if (exp_q.size() == 0) check("extra_elem", elem_data, 32'hFFFFFFFF);
                    else check("elem_data", elem_data, exp_q.pop_front());
                end
                if (done) begin
                    if (end_q.size() == 0) begin
                        check("extra_done", {31'h0, done}, 32'd0);
                    end else begin
                        e_exp = end_q.pop_front();
                        check("end_err", {31'h0, err}, {31'h0, e_exp.err});
                        check("end_count", elem_count, e_exp.cnt);
                        check("elems_left", exp_q.size(), 0);
                        check("reqs_left", addr_q.size(), 0);
                    end
                end
            end
            prev_stall = elem_valid && !elem_ready;
            prev_data = elem_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    int          it;
    logic [15:0] h;
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, err, elem_valid, mem_req, elem_count, elem_data, mem_addr},
              0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_walk(16'h0000, 1'b0, 1'b0, it);
        check("lat_nil", it, 2);

        mem[12'h010] = 16'hDEAD; mem[12'h011] = 16'h0020;
        mem[12'h020] = 16'h1234; mem[12'h021] = 16'h0030;
        mem[12'h030] = 16'hABCD; mem[12'h031] = 16'h0000;
        run_walk(16'h0010, 1'b0, 1'b0, it);
        ready_mode = 2;
        run_walk(16'h0010, 1'b0, 1'b0, it);
        ready_mode = 0;

        mem[12'h040] = 16'h5A5A; mem[12'h041] = 16'h0040;
        run_walk(16'h0040, 1'b0, 1'b0, it);

        run_walk(16'h0010, 1'b1, 1'b0, it);
        check("lat_timeout", it, TIMEOUT + 3);

        mem[12'hFFF] = 16'hBEEF;
        run_walk(16'h0FFF, 1'b0, 1'b0, it);
        run_walk(16'hAFFF, 1'b0, 1'b0, it);

        run_walk(16'h0010, 1'b0, 1'b1, it);

        // Reset while an element is being held on the stream.
        sb_off = 1'b1;
        ready_mode = 2;
        head_ptr = 16'h0010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        it = 0;
        while (!elem_valid && it < 50) begin
            @(posedge clk); #1;
            it++;
        end
        check("pre_reset_valid", {31'h0, elem_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {busy, done, err, elem_valid, mem_req, elem_count, elem_data, mem_addr}, 0);
        pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("busy_after_reset", {31'h0, busy}, 32'd0);
        exp_q.delete();
        addr_q.delete();
        end_q.delete();
        sb_off = 1'b0;

        ready_mode = 1;
        for (int t = 0; t < 30; t++) begin
            build_list(t, $urandom_range(0, 6), h);
            run_walk(h, 1'b0, 1'($urandom % 2), it);
        end
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
